// File: rtl/vga_pkg.sv
// Shared widths, default 640x480@60 timing and the per-box shadow record
// used by the VGA box compositor and its hit-test slices.
package vga_pkg;

  localparam int COLOR_W = 12;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int HALF_W  = 6;
  localparam int CNT_W   = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [HALF_W-1:0]  half;
    logic [COLOR_W-1:0] color;
    logic               enable;
    logic               blink;
  } box_t;

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_box_hit.sv
// Combinational hit test for one box against the current raster position.
// Differences are taken as signed 11-bit values so off-screen extents never wrap.
module vga_box_hit
  import vga_pkg::*;
(
  input  logic [CNT_W-1:0] h_cnt,
  input  logic [CNT_W-1:0] v_cnt,
  input  box_t             box,
  input  logic             blink_phase,
  output logic             hit
);

  logic signed [CNT_W:0] dx;
  logic signed [CNT_W:0] dy;
  logic        [CNT_W:0] abs_dx;
  logic        [CNT_W:0] abs_dy;
  logic        [CNT_W:0] half_ext;

  always_comb begin
    dx       = $signed({1'b0, h_cnt}) - $signed({1'b0, box.x});
    dy       = $signed({1'b0, v_cnt}) - $signed({{(CNT_W + 1 - Y_W){1'b0}}, box.y});
    abs_dx   = dx[CNT_W] ? -dx : dx;
    abs_dy   = dy[CNT_W] ? -dy : dy;
    half_ext = {{(CNT_W + 1 - HALF_W){1'b0}}, box.half};
    hit      = box.enable && (abs_dx <= half_ext) && (abs_dy <= half_ext)
               && !(box.blink && blink_phase);
  end

endmodule

// File: rtl/vga_box_compositor.sv
// VGA output stage: internal raster timing, frame-synchronous box shadowing,
// and a two-stage pipeline compositing prioritised boxes over a live background.
module vga_box_compositor
  import vga_pkg::*;
#(
  parameter int NUM_BOXES   = 4,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int BLINK_SHIFT = 4
) (
  input  logic                         clk_25mHz,
  input  logic                         reset,
  input  logic [NUM_BOXES*X_W-1:0]     box_x,
  input  logic [NUM_BOXES*Y_W-1:0]     box_y,
  input  logic [NUM_BOXES*HALF_W-1:0]  box_half,
  input  logic [NUM_BOXES*COLOR_W-1:0] box_color,
  input  logic [NUM_BOXES-1:0]         box_enable,
  input  logic [NUM_BOXES-1:0]         box_blink,
  input  logic [COLOR_W-1:0]           bg_color,
  output logic                         hSync,
  output logic                         vSync,
  output logic [3:0]                   VGA_R,
  output logic [3:0]                   VGA_G,
  output logic [3:0]                   VGA_B,
  output logic                         frame_start
);

  localparam int H_TOTAL  = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0]                  h_cnt_d, h_cnt_q;
  logic [CNT_W-1:0]                  v_cnt_d, v_cnt_q;
  logic [7:0]                        frame_cnt_d, frame_cnt_q;
  box_t [NUM_BOXES-1:0]              shadow_d, shadow_q;
  logic                              load;

  logic [NUM_BOXES-1:0]              hit_raw;
  logic                              hs_raw, vs_raw, active_raw;

  logic [NUM_BOXES-1:0]              hit_s1_d, hit_s1_q;
  logic [NUM_BOXES-1:0][COLOR_W-1:0] color_s1_d, color_s1_q;
  logic                              active_s1_d, active_s1_q;
  logic                              hs_s1_d, hs_s1_q;
  logic                              vs_s1_d, vs_s1_q;

  logic [COLOR_W-1:0]                rgb_d, rgb_q;
  logic                              hs_d, hs_q;
  logic                              vs_d, vs_q;

  // Shadow load happens on the first pixel of the first blanking line.
  always_comb begin
    load        = (h_cnt_q == '0) && (v_cnt_q == CNT_W'(V_ACTIVE));
    h_cnt_d     = h_cnt_q + CNT_W'(1);
    v_cnt_d     = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
    end
    frame_cnt_d = load ? frame_cnt_q + 8'd1 : frame_cnt_q;
    shadow_d    = shadow_q;
    if (load) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        shadow_d[i].x      = box_x[i*X_W +: X_W];
        shadow_d[i].y      = box_y[i*Y_W +: Y_W];
        shadow_d[i].half   = box_half[i*HALF_W +: HALF_W];
        shadow_d[i].color  = box_color[i*COLOR_W +: COLOR_W];
        shadow_d[i].enable = box_enable[i];
        shadow_d[i].blink  = box_blink[i];
      end
    end
  end

  always_comb begin
    hs_raw     = !((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END)));
    vs_raw     = !((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END)));
    active_raw = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
  end

  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_hit
    vga_box_hit u_hit (
      .h_cnt       (h_cnt_q),
      .v_cnt       (v_cnt_q),
      .box         (shadow_q[g]),
      .blink_phase (frame_cnt_q[BLINK_SHIFT]),
      .hit         (hit_raw[g])
    );
  end

  always_comb begin
    hit_s1_d    = hit_raw;
    active_s1_d = active_raw;
    hs_s1_d     = hs_raw;
    vs_s1_d     = vs_raw;
    for (int i = 0; i < NUM_BOXES; i++) begin
      color_s1_d[i] = shadow_q[i].color;
    end
  end

  // Later (higher-index) hits overwrite earlier ones, so the top layer wins.
  always_comb begin
    rgb_d = bg_color;
    for (int i = 0; i < NUM_BOXES; i++) begin
      if (hit_s1_q[i]) begin
        rgb_d = color_s1_q[i];
      end
    end
    if (!active_s1_q) begin
      rgb_d = '0;
    end
    hs_d = hs_s1_q;
    vs_d = vs_s1_q;
  end

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      shadow_q    <= '0;
      hit_s1_q    <= '0;
      color_s1_q  <= '0;
      active_s1_q <= 1'b0;
      hs_s1_q     <= 1'b1;
      vs_s1_q     <= 1'b1;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
      hit_s1_q    <= hit_s1_d;
      color_s1_q  <= color_s1_d;
      active_s1_q <= active_s1_d;
      hs_s1_q     <= hs_s1_d;
      vs_s1_q     <= vs_s1_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign frame_start = load;

endmodule
